// File: rtl/vec_issue_decoder.sv
// Registered, handshaked main decoder with vector-lane expansion.
// Scalar and illegal ops issue one beat, vector ops issue LANES beats.
module vec_issue_decoder #(
  parameter int OP_W   = 5,
  parameter int LANES  = 4,
  parameter int LANE_W = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   op,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              reg_write,
  output logic              alu_src,
  output logic              mem_write,
  output logic              result_src,
  output logic              branch,
  output logic              vectorial,
  output logic [1:0]        imm_src,
  output logic [1:0]        alu_op,
  output logic [LANE_W-1:0] lane_idx,
  output logic              last,
  output logic              illegal
);

  typedef enum logic {IDLE, ISSUE} state_e;

  typedef struct packed {
    logic       rw;
    logic       as;
    logic       mw;
    logic       rs;
    logic       br;
    logic       vec;
    logic [1:0] imm;
    logic [1:0] aop;
    logic       ill;
  } ctrl_t;

  state_e            state_q, state_d;
  logic [LANE_W-1:0] lane_q, lane_d;
  ctrl_t             ctrl_q, ctrl_d;
  ctrl_t             dec;
  logic [4:0]        o5;
  logic [OP_W-1:0]   op_hi;
  logic              last_int;
  logic              beat_done;

  // Combinational opcode decode; illegal ops carry only the illegal flag.
  always_comb begin
    o5    = op[4:0];
    op_hi = op >> 5;
    dec   = '0;
    dec.vec = o5 inside {5'b10000, 5'b10001, 5'b10010, 5'b10100,
                         5'b10101, 5'b10110, 5'b10111, 5'b11000};
    dec.ill = (|op_hi) | (o5[4] & ~dec.vec);
    if (dec.ill) begin
      dec.vec = 1'b0;
    end else begin
      dec.rw = ~(o5 inside {5'b01100, 5'b00111, 5'b01000, 5'b00001});
      if (o5 inside {5'b00000, 5'b01101, 5'b00011, 5'b01001, 5'b01100})
        dec.imm = 2'b01;
      else if (o5 inside {5'b00001, 5'b00111, 5'b01000})
        dec.imm = 2'b10;
      dec.as = o5 inside {5'b00000, 5'b00011, 5'b01001,
                          5'b01100, 5'b01101, 5'b00001};
      dec.mw = (o5 == 5'b00001);
      dec.rs = o5 inside {5'b00001, 5'b01010, 5'b01110, 5'b01111};
      dec.br = o5 inside {5'b00111, 5'b01000};
      if (o5 inside {5'b00100, 5'b00101, 5'b00110, 5'b01001})
        dec.aop = 2'b01;
    end
  end

  assign last_int  = ~ctrl_q.vec | (lane_q == LANE_W'(LANES - 1));
  assign beat_done = (state_q == ISSUE) & out_ready;
  assign in_ready  = ~flush &
                     ((state_q == IDLE) | (beat_done & last_int));

  // Next-state: flush wins, then accept, then lane advance / retire.
  always_comb begin
    state_d = state_q;
    lane_d  = lane_q;
    ctrl_d  = ctrl_q;
    if (flush) begin
      state_d = IDLE;
      lane_d  = '0;
    end else if (in_valid && in_ready) begin
      state_d = ISSUE;
      lane_d  = '0;
      ctrl_d  = dec;
    end else if (beat_done) begin
      if (last_int) begin
        state_d = IDLE;
        lane_d  = '0;
      end else begin
        lane_d = lane_q + LANE_W'(1);
      end
    end
  end

  // State, lane and captured-control registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      lane_q  <= '0;
      ctrl_q  <= '0;
    end else begin
      state_q <= state_d;
      lane_q  <= lane_d;
      ctrl_q  <= ctrl_d;
    end
  end

  assign out_valid  = (state_q == ISSUE);
  assign reg_write  = out_valid & ctrl_q.rw;
  assign alu_src    = out_valid & ctrl_q.as;
  assign mem_write  = out_valid & ctrl_q.mw;
  assign result_src = out_valid & ctrl_q.rs;
  assign branch     = out_valid & ctrl_q.br;
  assign vectorial  = out_valid & ctrl_q.vec;
  assign imm_src    = out_valid ? ctrl_q.imm : 2'b00;
  assign alu_op     = out_valid ? ctrl_q.aop : 2'b00;
  assign lane_idx   = out_valid ? lane_q : '0;
  assign last       = out_valid & last_int;
  assign illegal    = out_valid & ctrl_q.ill;

endmodule

// File: tb/tb_vec_issue_decoder.sv
// Testbench for vec_issue_decoder: table vectors, directed corner
// sequences and randomized traffic against a beat-queue model.
module tb_vec_issue_decoder;

  localparam int OP_W   = 6;
  localparam int LANES  = 4;
  localparam int LANE_W = 2;

  logic              clk = 1'b0;
  logic              rst, in_valid, in_ready, flush;
  logic [OP_W-1:0]   op;
  logic              out_valid, out_ready;
  logic              reg_write, alu_src, mem_write, result_src;
  logic              branch, vectorial, last, illegal;
  logic [1:0]        imm_src, alu_op;
  logic [LANE_W-1:0] lane_idx;

  always #5 clk = ~clk;

  vec_issue_decoder #(.OP_W(OP_W), .LANES(LANES)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .reg_write(reg_write), .alu_src(alu_src),
    .mem_write(mem_write), .result_src(result_src), .branch(branch),
    .vectorial(vectorial), .imm_src(imm_src), .alu_op(alu_op),
    .lane_idx(lane_idx), .last(last), .illegal(illegal)
  );

  int tests = 0;
  int fails = 0;

  // Pending beats of the op in flight, as observation words with
  // in_ready (bit 14) left clear.
  logic [15:0] q[$];

  typedef struct {
    logic [OP_W-1:0] op;
    logic [10:0]     ctrl;
    logic            lst;
  } vec_t;

  vec_t tbl[14];

  // {valid, in_ready, rw, as, mw, rs, br, vec, imm, aop, lane, last, ill}
  function automatic logic [15:0] obs();
    return {out_valid, in_ready, reg_write, alu_src, mem_write,
            result_src, branch, vectorial, imm_src, alu_op,
            lane_idx, last, illegal};
  endfunction

  // {rw, as, mw, rs, br, vec, imm[1:0], aop[1:0], ill}
  function automatic logic [10:0] ref_ctrl(input logic [OP_W-1:0] o);
    logic [4:0] c;
    logic       v, rw, as, mw, rs, br;
    logic [1:0] imm, aop;
    c = o[4:0];
    v = c inside {5'h10, 5'h11, 5'h12, 5'h14,
                  5'h15, 5'h16, 5'h17, 5'h18};
    if (o[5] || (c[4] && !v)) return 11'b1;
    rw  = !(c inside {5'h0C, 5'h07, 5'h08, 5'h01});
    imm = (c inside {5'h00, 5'h0D, 5'h03, 5'h09, 5'h0C}) ? 2'b01 :
          (c inside {5'h01, 5'h07, 5'h08}) ? 2'b10 : 2'b00;
    as  = c inside {5'h00, 5'h03, 5'h09, 5'h0C, 5'h0D, 5'h01};
    mw  = (c == 5'h01);
    rs  = c inside {5'h01, 5'h0A, 5'h0E, 5'h0F};
    br  = c inside {5'h07, 5'h08};
    aop = (c inside {5'h04, 5'h05, 5'h06, 5'h09}) ? 2'b01 : 2'b00;
    return {rw, as, mw, rs, br, v, imm, aop, 1'b0};
  endfunction

  task automatic push_op(input logic [OP_W-1:0] o);
    logic [10:0] c;
    int          n;
    c = ref_ctrl(o);
    n = c[5] ? LANES : 1;
    for (int i = 0; i < n; i++)
      q.push_back({1'b1, 1'b0, c[10:1], 2'(i), (i == n - 1), c[0]});
  endtask

  task automatic chk(input string nm, input logic [15:0] a,
                     input logic [15:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, a, e);
    end
  endtask

  // One clock: drive, compare against model at negedge, advance model.
  task automatic step(input bit r, input bit iv,
                      input logic [OP_W-1:0] o, input bit fl,
                      input bit ordy, input bit ck,
                      output logic [15:0] got);
    logic        eir;
    logic [15:0] e;
    rst = r; in_valid = iv; op = o; flush = fl; out_ready = ordy;
    @(negedge clk);
    eir = !fl && (q.size() == 0 || (ordy && q[0][1]));
    e = (q.size() != 0) ? q[0] : 16'h0;
    e[14] = eir;
    got = obs();
    if (ck) chk("model", got, e);
    @(posedge clk);
    if (r || fl) begin
      q.delete();
    end else begin
      if (q.size() != 0 && ordy) void'(q.pop_front());
      if (iv && eir) push_op(o);
    end
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    logic [15:0]     g;
    logic [OP_W-1:0] ro;
    tbl[0]  = '{6'b000001, 11'b0_1_1_1_0_0_10_00_0, 1'b1};
    tbl[1]  = '{6'b000100, 11'b1_0_0_0_0_0_00_01_0, 1'b1};
    tbl[2]  = '{6'b000000, 11'b1_1_0_0_0_0_01_00_0, 1'b1};
    tbl[3]  = '{6'b000111, 11'b0_0_0_0_1_0_10_00_0, 1'b1};
    tbl[4]  = '{6'b001100, 11'b0_1_0_0_0_0_01_00_0, 1'b1};
    tbl[5]  = '{6'b001001, 11'b1_1_0_0_0_0_01_01_0, 1'b1};
    tbl[6]  = '{6'b001111, 11'b1_0_0_1_0_0_00_00_0, 1'b1};
    tbl[7]  = '{6'b000010, 11'b1_0_0_0_0_0_00_00_0, 1'b1};
    tbl[8]  = '{6'b010011, 11'b0_0_0_0_0_0_00_00_1, 1'b1};
    tbl[9]  = '{6'b100000, 11'b0_0_0_0_0_0_00_00_1, 1'b1};
    tbl[10] = '{6'b100100, 11'b0_0_0_0_0_0_00_00_1, 1'b1};
    tbl[11] = '{6'b010100, 11'b1_0_0_0_0_1_00_00_0, 1'b0};
    tbl[12] = '{6'b001000, 11'b0_0_0_0_1_0_10_00_0, 1'b1};
    tbl[13] = '{6'b001010, 11'b1_0_0_1_0_0_00_00_0, 1'b1};

    step(1, 0, '0, 0, 1, 0, g);
    step(1, 0, '0, 0, 1, 0, g);
    step(0, 0, '0, 0, 1, 1, g);
    chk("reset_idle", g, 16'h4000);

    // First beat of each table op, held by out_ready=0, then flushed.
    for (int i = 0; i < 14; i++) begin
      step(0, 1, tbl[i].op, 0, 0, 1, g);
      step(0, 0, '0, 0, 0, 1, g);
      chk($sformatf("tbl%0d", i),
          {3'b0, g[15], g[13:4], g[0], g[1]},
          {3'b0, 1'b1, tbl[i].ctrl, tbl[i].lst});
      step(0, 0, '0, 1, 0, 1, g);
    end

    // Vector op expands into four lanes.
    step(0, 1, 6'b010100, 0, 1, 1, g);
    for (int i = 0; i < LANES; i++) begin
      step(0, 0, '0, 0, 1, 1, g);
      chk($sformatf("vec_lane%0d", i),
          {12'b0, g[3:2], g[1], g[14]},
          {12'b0, 2'(i), (i == LANES - 1), (i == LANES - 1)});
    end
    step(0, 0, '0, 0, 1, 1, g);
    chk("vec_done", g, 16'h4000);

    // Back-pressure holds a branch beat.
    step(0, 1, 6'b000111, 0, 0, 1, g);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, '0, 0, 0, 1, g);
      chk("bp_hold", g, 16'b1_0_0_0_0_0_1_0_10_00_00_1_0);
    end
    step(0, 0, '0, 0, 1, 1, g);
    step(0, 0, '0, 0, 1, 1, g);
    chk("bp_retired", g, 16'h4000);

    // Back-to-back scalars, no bubble.
    step(0, 1, 6'b000100, 0, 1, 1, g);
    step(0, 1, 6'b000000, 0, 1, 1, g);
    chk("b2b_first", g, 16'b1_1_1_0_0_0_0_0_00_01_00_1_0);
    step(0, 0, '0, 0, 1, 1, g);
    chk("b2b_second", g, 16'b1_1_1_1_0_0_0_0_01_00_00_1_0);

    // Flush during lane 1 while a new op is presented.
    step(0, 1, 6'b011000, 0, 1, 1, g);
    step(0, 0, '0, 0, 1, 1, g);
    step(0, 1, 6'b000001, 1, 0, 1, g);
    chk("flush_lane1", {14'b0, g[3:2]}, 16'd1);
    chk("flush_noready", {15'b0, g[14]}, 16'd0);
    step(0, 0, '0, 0, 1, 1, g);
    chk("flush_after", g, 16'h4000);

    // Reset mid-vector.
    step(0, 1, 6'b011000, 0, 1, 1, g);
    step(0, 0, '0, 0, 1, 1, g);
    step(1, 0, '0, 0, 0, 1, g);
    step(0, 0, '0, 0, 0, 1, g);
    chk("rst_midvec", g, 16'h4000);

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 9) == 0)
        ro = OP_W'($urandom_range(0, 63));
      else
        ro = OP_W'($urandom_range(0, 31));
      step($urandom_range(0, 63) == 0, $urandom_range(0, 9) < 7, ro,
           $urandom_range(0, 15) == 0, $urandom_range(0, 9) < 7, 1, g);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
